// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the inverse key-schedule datapath:
// widths, round-constant table and word-level helpers.
package aes_pkg;

  localparam int AES_KEY_W = 128;
  localparam int WORD_W    = 32;

  typedef logic [WORD_W-1:0]    word_t;
  typedef logic [AES_KEY_W-1:0] key_t;

  // Indices outside 1..10 have no round constant and contribute zero.
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] rc;
    case (idx)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  // Word 0 is the most significant word of the key.
  function automatic word_t get_word(input key_t k, input int unsigned idx);
    return k[AES_KEY_W-1-WORD_W*idx -: WORD_W];
  endfunction

  function automatic key_t pack_words(input word_t w0, input word_t w1,
                                      input word_t w2, input word_t w3);
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational FIPS-197 forward S-box, one byte in, one byte out.
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  always_comb begin
    o_byte = 8'h00;
    case (i_byte)
      8'h00: o_byte = 8'h63; 8'h01: o_byte = 8'h7c; 8'h02: o_byte = 8'h77; 8'h03: o_byte = 8'h7b;
      8'h04: o_byte = 8'hf2; 8'h05: o_byte = 8'h6b; 8'h06: o_byte = 8'h6f; 8'h07: o_byte = 8'hc5;
      8'h08: o_byte = 8'h30; 8'h09: o_byte = 8'h01; 8'h0a: o_byte = 8'h67; 8'h0b: o_byte = 8'h2b;
      8'h0c: o_byte = 8'hfe; 8'h0d: o_byte = 8'hd7; 8'h0e: o_byte = 8'hab; 8'h0f: o_byte = 8'h76;
      8'h10: o_byte = 8'hca; 8'h11: o_byte = 8'h82; 8'h12: o_byte = 8'hc9; 8'h13: o_byte = 8'h7d;
      8'h14: o_byte = 8'hfa; 8'h15: o_byte = 8'h59; 8'h16: o_byte = 8'h47; 8'h17: o_byte = 8'hf0;
      8'h18: o_byte = 8'had; 8'h19: o_byte = 8'hd4; 8'h1a: o_byte = 8'ha2; 8'h1b: o_byte = 8'haf;
      8'h1c: o_byte = 8'h9c; 8'h1d: o_byte = 8'ha4; 8'h1e: o_byte = 8'h72; 8'h1f: o_byte = 8'hc0;
      8'h20: o_byte = 8'hb7; 8'h21: o_byte = 8'hfd; 8'h22: o_byte = 8'h93; 8'h23: o_byte = 8'h26;
      8'h24: o_byte = 8'h36; 8'h25: o_byte = 8'h3f; 8'h26: o_byte = 8'hf7; 8'h27: o_byte = 8'hcc;
      8'h28: o_byte = 8'h34; 8'h29: o_byte = 8'ha5; 8'h2a: o_byte = 8'he5; 8'h2b: o_byte = 8'hf1;
      8'h2c: o_byte = 8'h71; 8'h2d: o_byte = 8'hd8; 8'h2e: o_byte = 8'h31; 8'h2f: o_byte = 8'h15;
      8'h30: o_byte = 8'h04; 8'h31: o_byte = 8'hc7; 8'h32: o_byte = 8'h23; 8'h33: o_byte = 8'hc3;
      8'h34: o_byte = 8'h18; 8'h35: o_byte = 8'h96; 8'h36: o_byte = 8'h05; 8'h37: o_byte = 8'h9a;
      8'h38: o_byte = 8'h07; 8'h39: o_byte = 8'h12; 8'h3a: o_byte = 8'h80; 8'h3b: o_byte = 8'he2;
      8'h3c: o_byte = 8'heb; 8'h3d: o_byte = 8'h27; 8'h3e: o_byte = 8'hb2; 8'h3f: o_byte = 8'h75;
      8'h40: o_byte = 8'h09; 8'h41: o_byte = 8'h83; 8'h42: o_byte = 8'h2c; 8'h43: o_byte = 8'h1a;
      8'h44: o_byte = 8'h1b; 8'h45: o_byte = 8'h6e; 8'h46: o_byte = 8'h5a; 8'h47: o_byte = 8'ha0;
      8'h48: o_byte = 8'h52; 8'h49: o_byte = 8'h3b; 8'h4a: o_byte = 8'hd6; 8'h4b: o_byte = 8'hb3;
      8'h4c: o_byte = 8'h29; 8'h4d: o_byte = 8'he3; 8'h4e: o_byte = 8'h2f; 8'h4f: o_byte = 8'h84;
      8'h50: o_byte = 8'h53; 8'h51: o_byte = 8'hd1; 8'h52: o_byte = 8'h00; 8'h53: o_byte = 8'hed;
      8'h54: o_byte = 8'h20; 8'h55: o_byte = 8'hfc; 8'h56: o_byte = 8'hb1; 8'h57: o_byte = 8'h5b;
      8'h58: o_byte = 8'h6a; 8'h59: o_byte = 8'hcb; 8'h5a: o_byte = 8'hbe; 8'h5b: o_byte = 8'h39;
      8'h5c: o_byte = 8'h4a; 8'h5d: o_byte = 8'h4c; 8'h5e: o_byte = 8'h58; 8'h5f: o_byte = 8'hcf;
      8'h60: o_byte = 8'hd0; 8'h61: o_byte = 8'hef; 8'h62: o_byte = 8'haa; 8'h63: o_byte = 8'hfb;
      8'h64: o_byte = 8'h43; 8'h65: o_byte = 8'h4d; 8'h66: o_byte = 8'h33; 8'h67: o_byte = 8'h85;
      8'h68: o_byte = 8'h45; 8'h69: o_byte = 8'hf9; 8'h6a: o_byte = 8'h02; 8'h6b: o_byte = 8'h7f;
      8'h6c: o_byte = 8'h50; 8'h6d: o_byte = 8'h3c; 8'h6e: o_byte = 8'h9f; 8'h6f: o_byte = 8'ha8;
      8'h70: o_byte = 8'h51; 8'h71: o_byte = 8'ha3; 8'h72: o_byte = 8'h40; 8'h73: o_byte = 8'h8f;
      8'h74: o_byte = 8'h92; 8'h75: o_byte = 8'h9d; 8'h76: o_byte = 8'h38; 8'h77: o_byte = 8'hf5;
      8'h78: o_byte = 8'hbc; 8'h79: o_byte = 8'hb6; 8'h7a: o_byte = 8'hda; 8'h7b: o_byte = 8'h21;
      8'h7c: o_byte = 8'h10; 8'h7d: o_byte = 8'hff; 8'h7e: o_byte = 8'hf3; 8'h7f: o_byte = 8'hd2;
      8'h80: o_byte = 8'hcd; 8'h81: o_byte = 8'h0c; 8'h82: o_byte = 8'h13; 8'h83: o_byte = 8'hec;
      8'h84: o_byte = 8'h5f; 8'h85: o_byte = 8'h97; 8'h86: o_byte = 8'h44; 8'h87: o_byte = 8'h17;
      8'h88: o_byte = 8'hc4; 8'h89: o_byte = 8'ha7; 8'h8a: o_byte = 8'h7e; 8'h8b: o_byte = 8'h3d;
      8'h8c: o_byte = 8'h64; 8'h8d: o_byte = 8'h5d; 8'h8e: o_byte = 8'h19; 8'h8f: o_byte = 8'h73;
      8'h90: o_byte = 8'h60; 8'h91: o_byte = 8'h81; 8'h92: o_byte = 8'h4f; 8'h93: o_byte = 8'hdc;
      8'h94: o_byte = 8'h22; 8'h95: o_byte = 8'h2a; 8'h96: o_byte = 8'h90; 8'h97: o_byte = 8'h88;
      8'h98: o_byte = 8'h46; 8'h99: o_byte = 8'hee; 8'h9a: o_byte = 8'hb8; 8'h9b: o_byte = 8'h14;
      8'h9c: o_byte = 8'hde; 8'h9d: o_byte = 8'h5e; 8'h9e: o_byte = 8'h0b; 8'h9f: o_byte = 8'hdb;
      8'ha0: o_byte = 8'he0; 8'ha1: o_byte = 8'h32; 8'ha2: o_byte = 8'h3a; 8'ha3: o_byte = 8'h0a;
      8'ha4: o_byte = 8'h49; 8'ha5: o_byte = 8'h06; 8'ha6: o_byte = 8'h24; 8'ha7: o_byte = 8'h5c;
      8'ha8: o_byte = 8'hc2; 8'ha9: o_byte = 8'hd3; 8'haa: o_byte = 8'hac; 8'hab: o_byte = 8'h62;
      8'hac: o_byte = 8'h91; 8'had: o_byte = 8'h95; 8'hae: o_byte = 8'he4; 8'haf: o_byte = 8'h79;
      8'hb0: o_byte = 8'he7; 8'hb1: o_byte = 8'hc8; 8'hb2: o_byte = 8'h37; 8'hb3: o_byte = 8'h6d;
      8'hb4: o_byte = 8'h8d; 8'hb5: o_byte = 8'hd5; 8'hb6: o_byte = 8'h4e; 8'hb7: o_byte = 8'ha9;
      8'hb8: o_byte = 8'h6c; 8'hb9: o_byte = 8'h56; 8'hba: o_byte = 8'hf4; 8'hbb: o_byte = 8'hea;
      8'hbc: o_byte = 8'h65; 8'hbd: o_byte = 8'h7a; 8'hbe: o_byte = 8'hae; 8'hbf: o_byte = 8'h08;
      8'hc0: o_byte = 8'hba; 8'hc1: o_byte = 8'h78; 8'hc2: o_byte = 8'h25; 8'hc3: o_byte = 8'h2e;
      8'hc4: o_byte = 8'h1c; 8'hc5: o_byte = 8'ha6; 8'hc6: o_byte = 8'hb4; 8'hc7: o_byte = 8'hc6;
      8'hc8: o_byte = 8'he8; 8'hc9: o_byte = 8'hdd; 8'hca: o_byte = 8'h74; 8'hcb: o_byte = 8'h1f;
      8'hcc: o_byte = 8'h4b; 8'hcd: o_byte = 8'hbd; 8'hce: o_byte = 8'h8b; 8'hcf: o_byte = 8'h8a;
      8'hd0: o_byte = 8'h70; 8'hd1: o_byte = 8'h3e; 8'hd2: o_byte = 8'hb5; 8'hd3: o_byte = 8'h66;
      8'hd4: o_byte = 8'h48; 8'hd5: o_byte = 8'h03; 8'hd6: o_byte = 8'hf6; 8'hd7: o_byte = 8'h0e;
      8'hd8: o_byte = 8'h61; 8'hd9: o_byte = 8'h35; 8'hda: o_byte = 8'h57; 8'hdb: o_byte = 8'hb9;
      8'hdc: o_byte = 8'h86; 8'hdd: o_byte = 8'hc1; 8'hde: o_byte = 8'h1d; 8'hdf: o_byte = 8'h9e;
      8'he0: o_byte = 8'he1; 8'he1: o_byte = 8'hf8; 8'he2: o_byte = 8'h98; 8'he3: o_byte = 8'h11;
      8'he4: o_byte = 8'h69; 8'he5: o_byte = 8'hd9; 8'he6: o_byte = 8'h8e; 8'he7: o_byte = 8'h94;
      8'he8: o_byte = 8'h9b; 8'he9: o_byte = 8'h1e; 8'hea: o_byte = 8'h87; 8'heb: o_byte = 8'he9;
      8'hec: o_byte = 8'hce; 8'hed: o_byte = 8'h55; 8'hee: o_byte = 8'h28; 8'hef: o_byte = 8'hdf;
      8'hf0: o_byte = 8'h8c; 8'hf1: o_byte = 8'ha1; 8'hf2: o_byte = 8'h89; 8'hf3: o_byte = 8'h0d;
      8'hf4: o_byte = 8'hbf; 8'hf5: o_byte = 8'he6; 8'hf6: o_byte = 8'h42; 8'hf7: o_byte = 8'h68;
      8'hf8: o_byte = 8'h41; 8'hf9: o_byte = 8'h99; 8'hfa: o_byte = 8'h2d; 8'hfb: o_byte = 8'h0f;
      8'hfc: o_byte = 8'hb0; 8'hfd: o_byte = 8'h54; 8'hfe: o_byte = 8'hbb; 8'hff: o_byte = 8'h16;
      default: o_byte = 8'h00;
    endcase
  end

endmodule

// File: rtl/round_key.sv
// AES-128 reverse key schedule: walks K(r-1) back two rounds to K(r-3)
// through two combinational inverse steps and one output register.
module round_key
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           round,
  input  logic [AES_KEY_W-1:0] key_in,
  output logic [AES_KEY_W-1:0] key_out
);

  key_t w_key [3];
  key_t r_key;

  assign w_key[0] = key_in;

  // Step s undoes expansion round (round-1-s); the 4-bit subtraction wraps
  // for round < 2, which lands on indices with no round constant.
  for (genvar s = 0; s < 2; s++) begin : g_inv
    localparam logic [3:0] STEP = 4'(s + 1);

    logic [3:0] w_rc_idx;
    word_t      w_p0, w_p1, w_p2, w_p3;
    word_t      w_rot, w_sub;

    assign w_rc_idx = round - STEP;
    assign w_p3     = get_word(w_key[s], 3) ^ get_word(w_key[s], 2);
    assign w_p2     = get_word(w_key[s], 2) ^ get_word(w_key[s], 1);
    assign w_p1     = get_word(w_key[s], 1) ^ get_word(w_key[s], 0);
    assign w_rot    = rot_word(w_p3);

    for (genvar b = 0; b < 4; b++) begin : g_sbox
      aes_sbox u_sbox (
        .i_byte (w_rot[8*b +: 8]),
        .o_byte (w_sub[8*b +: 8])
      );
    end

    assign w_p0         = get_word(w_key[s], 0) ^ w_sub ^ {rcon(w_rc_idx), 24'h0};
    assign w_key[s + 1] = pack_words(w_p0, w_p1, w_p2, w_p3);
  end

  // Output register: the only state, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_key <= '0;
    else        r_key <= w_key[2];
  end

  assign key_out = r_key;

endmodule

// File: tb/tb_round_key.sv
// Bench for round_key: known-answer table, latency/reset sequences and
// random vectors against a GF(2^8)-arithmetic reference model.
module tb_round_key;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   round;
  logic [127:0] key_in;
  logic [127:0] key_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  round_key dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .round   (round),
    .key_in  (key_in),
    .key_out (key_out)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] m_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int n = 0; n < 8; n++) begin
      if (b[n]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] m_rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  // S-box from its definition: multiplicative inverse, then affine map.
  function automatic logic [7:0] m_sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    if (x == 8'h00) inv = 8'h00;
    else for (int n = 0; n < 254; n++) inv = m_gmul(inv, x);
    return inv ^ m_rotl8(inv, 1) ^ m_rotl8(inv, 2) ^ m_rotl8(inv, 3) ^ m_rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] m_rcon(input int i);
    logic [7:0] r;
    if (i < 1 || i > 10) return 8'h00;
    r = 8'h01;
    for (int n = 1; n < i; n++) r = m_gmul(r, 8'h02);
    return r;
  endfunction

  function automatic logic [127:0] m_inv(input logic [127:0] k, input int i);
    logic [31:0] w [4];
    logic [31:0] t;
    logic [7:0]  tb [4];
    logic [31:0] sub;
    for (int j = 0; j < 4; j++) w[j] = k[127-32*j -: 32];
    t = w[3] ^ w[2];
    for (int j = 0; j < 4; j++) tb[j] = t[31-8*j -: 8];
    for (int j = 0; j < 4; j++) sub[31-8*j -: 8] = m_sbox(tb[(j + 1) % 4]);
    return {w[0] ^ sub ^ {m_rcon(i), 24'h0}, w[1] ^ w[0], w[2] ^ w[1], t};
  endfunction

  function automatic logic [127:0] m_round_key(input logic [3:0] r, input logic [127:0] k);
    return m_inv(m_inv(k, int'(r) - 1), int'(r) - 2);
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: key_out=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic apply(input logic [3:0] r, input logic [127:0] k,
                       input logic [127:0] exp, input string name);
    @(negedge clk);
    round  = r;
    key_in = k;
    @(posedge clk);
    #1 check(name, key_out, exp);
  endtask

  typedef struct {
    logic [3:0]   round;
    logic [127:0] key;
    logic [127:0] exp;
  } vec_t;

  localparam logic [127:0] K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] K3  = 128'h3d80477d4716fe3e1e237e446d7a883b;
  localparam logic [127:0] K4  = 128'hef44a541a8525b7fb671253bdb0bad00;
  localparam logic [127:0] K6  = 128'h6d88a37a110b3efddbf98641ca0093fd;
  localparam logic [127:0] K8  = 128'head27321b58dbad2312bf5607f8d292f;
  localparam logic [127:0] K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  vec_t vecs [5];

  initial begin
    logic [3:0]   r;
    logic [127:0] k;

    vecs[0] = '{4'd4,  K3,  K1};
    vecs[1] = '{4'd3,  K2,  K0};
    vecs[2] = '{4'd5,  K4,  K2};
    vecs[3] = '{4'd11, K10, K8};
    vecs[4] = '{4'd7,  K6,  K4};

    // Reset with arbitrary inputs clears the output without any edge.
    rst_n  = 1'b0;
    round  = 4'd9;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    #2 check("reset_async", key_out, 128'h0);
    @(posedge clk);
    #1 check("reset_hold_edge", key_out, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("reset_release_no_edge", key_out, 128'h0);

    foreach (vecs[i]) apply(vecs[i].round, vecs[i].key, vecs[i].exp, $sformatf("kat_%0d", i));

    // Inputs moving between edges must not reach the output.
    apply(4'd3, K2, K0, "lat_base");
    @(negedge clk);
    round  = 4'd11;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    #1 check("lat_hold_a", key_out, K0);
    #2;
    round  = 4'd5;
    key_in = K4;
    #1 check("lat_hold_b", key_out, K0);
    @(posedge clk);
    #1 check("lat_update", key_out, K2);

    // Back-to-back random vectors, one per cycle, mostly legal rounds.
    for (int n = 0; n < 120; n++) begin
      r = (n % 4 == 3) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(3, 11));
      k = {$urandom, $urandom, $urandom, $urandom};
      apply(r, k, m_round_key(r, k), $sformatf("rand_%0d_r%0d", n, r));
    end

    // Explicit out-of-range rounds, including wrap-around indices.
    foreach (vecs[i]) begin
      r = (i % 2 == 0) ? 4'(i) : 4'(11 + i);
      k = {$urandom, $urandom, $urandom, $urandom};
      apply(r, k, m_round_key(r, k), $sformatf("oor_r%0d", r));
    end

    // Mid-stream reset discards the registered result immediately.
    apply(4'd11, K10, K8, "pre_reset");
    #3 rst_n = 1'b0;
    #1 check("mid_reset_async", key_out, 128'h0);
    @(negedge clk);
    round  = 4'd4;
    key_in = K3;
    @(posedge clk);
    #1 check("mid_reset_hold", key_out, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("resume", key_out, K1);
    apply(4'd5, K4, K2, "resume_next");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
